// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_stall;
  logic                  if_valid;
  logic [31:0]           if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [1:0]            d_size;
  logic                  d_unsigned;
  logic [31:0]           d_addr;
  logic [31:0]           d_wdata;
  logic                  d_stall;
  logic                  d_valid;
  logic [31:0]           d_rdata;
  logic                  d_misalign;

  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_stall, if_valid, if_rdata,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_stall, d_valid, d_rdata, d_misalign,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_stall, if_valid, if_rdata,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_stall, d_valid, d_rdata, d_misalign,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read, byte-writable memory port between instruction fetch
// and load/store, with starvation relief for fetch and load realignment/extension.
module mem_port_arbiter #(
  parameter int DEPTH_LOG2 = 10,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        grant_if;
  logic        grant_d;
  logic        d_mis;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // response tag for the access granted last cycle
  logic        t_vld;
  logic        t_d;
  logic        t_we;
  logic [1:0]  t_size;
  logic        t_uns;
  logic [1:0]  t_lane;
  logic        t_mis;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic        if_valid_q;
  logic [31:0] if_rdata_q;
  logic        d_valid_q;
  logic [31:0] d_rdata_q;
  logic        d_misalign_q;

  logic        unused_bits;
  assign unused_bits = ^{bus.if_addr[1:0], bus.if_addr[31:DEPTH_LOG2+2],
                         bus.d_addr[31:DEPTH_LOG2+2]};

  assign d_mis = (bus.d_size == 2'b01) ? bus.d_addr[0]
                                       : (bus.d_size[1] & (|bus.d_addr[1:0]));

  assign grant_d  = !rst && bus.d_req && !(bus.if_req && (starve_cnt >= STARVE_LIM));
  assign grant_if = !rst && bus.if_req && !grant_d;

  assign bus.if_stall = bus.if_req && !grant_if;
  assign bus.d_stall  = bus.d_req && !grant_d;

  always_comb begin
    st_be   = 4'b1111;
    st_data = bus.d_wdata;
    case (bus.d_size)
      2'b00: begin
        st_be   = 4'b0001 << bus.d_addr[1:0];
        st_data = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = bus.d_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // a misaligned data access still consumes the grant but never touches memory
  assign bus.mem_en    = grant_if || (grant_d && !d_mis);
  assign bus.mem_we    = (grant_d && bus.d_we && !d_mis) ? st_be : 4'b0000;
  assign bus.mem_addr  = grant_d ? bus.d_addr[DEPTH_LOG2+1:2] : bus.if_addr[DEPTH_LOG2+1:2];
  assign bus.mem_wdata = st_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req || grant_if) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_vld  <= 1'b0;
      t_d    <= 1'b0;
      t_we   <= 1'b0;
      t_size <= 2'b00;
      t_uns  <= 1'b0;
      t_lane <= 2'b00;
      t_mis  <= 1'b0;
    end else begin
      t_vld  <= grant_if || grant_d;
      t_d    <= grant_d;
      t_we   <= bus.d_we;
      t_size <= bus.d_size;
      t_uns  <= bus.d_unsigned;
      t_lane <= bus.d_addr[1:0];
      t_mis  <= grant_d && d_mis;
    end
  end

  always_comb begin
    case (t_lane)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = t_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (t_size)
      2'b00:   ld_data = {{24{~t_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~t_uns & ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q   <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= 32'd0;
      d_misalign_q <= 1'b0;
    end else begin
      if_valid_q   <= t_vld && !t_d;
      d_valid_q    <= t_vld && t_d;
      d_misalign_q <= t_vld && t_d && t_mis;
      if (t_vld && !t_d) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (t_vld && t_d) begin
        d_rdata_q <= (t_we || t_mis) ? 32'd0 : ld_data;
      end
    end
  end

  assign bus.if_valid   = if_valid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_misalign = d_misalign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-writable
// synchronous-read memory behind the port.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:1023];
  logic [31:0] rdq;

  mem_port_arbiter_if #(.DEPTH_LOG2(10)) bus ();

  mem_port_arbiter #(.DEPTH_LOG2(10), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_en) begin
      rdq <= mem[bus.mem_addr];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end
  assign bus.mem_rdata = rdq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    cyc();
  endtask

  // one isolated data access: grant-cycle port checks, then the N+2 response
  task automatic d_op(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd, input logic exp_mis);
    bus.d_req      = 1'b1;
    bus.d_we       = we;
    bus.d_size     = size;
    bus.d_unsigned = uns;
    bus.d_addr     = addr;
    bus.d_wdata    = wdata;
    #1;
    chk({tag, ".stall"}, 32'(bus.d_stall), 32'd0);
    chk({tag, ".mem_en"}, 32'(bus.mem_en), 32'(exp_en));
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(exp_we));
    if (exp_en) chk({tag, ".mem_addr"}, 32'(bus.mem_addr), {22'd0, addr[11:2]});
    if (we && exp_en) chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wd);
    cyc();
    bus.d_req = 1'b0;
    #1;
    chk({tag, ".early"}, 32'(bus.d_valid), 32'd0);
    cyc();
    #1;
    chk({tag, ".valid"}, 32'(bus.d_valid), 32'd1);
    chk({tag, ".rdata"}, bus.d_rdata, exp_rd);
    chk({tag, ".misalign"}, 32'(bus.d_misalign), 32'(exp_mis));
    cyc();
    #1;
    chk({tag, ".pulse"}, 32'(bus.d_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    pl_en          = 1'b0;
    pl_addr        = '0;
    pl_data        = '0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_size     = 2'b10;
    bus.d_unsigned = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    cyc();
    preload(10'd0,  32'h02114020);
    preload(10'd1,  32'h02534821);
    preload(10'd2,  32'h02945022);
    preload(10'd4,  32'h8081F2F3);
    preload(10'd5,  32'h11223344);
    preload(10'd8,  32'h00000000);
    preload(10'd12, 32'h00000000);
    pl_en = 1'b0;

    // requests during reset are never granted
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h10;
    #1;
    chk("rst.if_stall", 32'(bus.if_stall), 32'd1);
    chk("rst.d_stall", 32'(bus.d_stall), 32'd1);
    chk("rst.mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst.if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst.d_valid", 32'(bus.d_valid), 32'd0);
    chk("rst.d_misalign", 32'(bus.d_misalign), 32'd0);
    chk("rst.if_rdata", bus.if_rdata, 32'd0);
    chk("rst.d_rdata", bus.d_rdata, 32'd0);
    cyc();

    // fetch stream
    rst         = 1'b0;
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    #1;
    chk("f0.stall", 32'(bus.if_stall), 32'd0);
    chk("f0.mem_en", 32'(bus.mem_en), 32'd1);
    chk("f0.mem_addr", 32'(bus.mem_addr), 32'd0);
    cyc();
    bus.if_addr = 32'h4;
    #1;
    chk("f1.stall", 32'(bus.if_stall), 32'd0);
    chk("f1.if_valid", 32'(bus.if_valid), 32'd0);
    chk("f1.mem_addr", 32'(bus.mem_addr), 32'd1);
    cyc();
    bus.if_addr = 32'h8;
    #1;
    chk("f2.stall", 32'(bus.if_stall), 32'd0);
    chk("f2.if_valid", 32'(bus.if_valid), 32'd1);
    chk("f2.if_rdata", bus.if_rdata, 32'h02114020);
    cyc();
    bus.if_req = 1'b0;
    #1;
    chk("f3.if_valid", 32'(bus.if_valid), 32'd1);
    chk("f3.if_rdata", bus.if_rdata, 32'h02534821);
    cyc();
    #1;
    chk("f4.if_valid", 32'(bus.if_valid), 32'd1);
    chk("f4.if_rdata", bus.if_rdata, 32'h02945022);
    chk("f4.d_valid", 32'(bus.d_valid), 32'd0);
    cyc();
    #1;
    chk("f5.if_valid", 32'(bus.if_valid), 32'd0);

    // loads
    d_op("lb",    1'b0, 2'b00, 1'b0, 32'h10,   '0, 1'b1, 4'b0000, '0, 32'hFFFFFFF3, 1'b0);
    d_op("lbu",   1'b0, 2'b00, 1'b1, 32'h11,   '0, 1'b1, 4'b0000, '0, 32'h000000F2, 1'b0);
    d_op("lh",    1'b0, 2'b01, 1'b0, 32'h12,   '0, 1'b1, 4'b0000, '0, 32'hFFFF8081, 1'b0);
    d_op("lhu",   1'b0, 2'b01, 1'b1, 32'h12,   '0, 1'b1, 4'b0000, '0, 32'h00008081, 1'b0);
    d_op("lw",    1'b0, 2'b10, 1'b1, 32'h10,   '0, 1'b1, 4'b0000, '0, 32'h8081F2F3, 1'b0);
    d_op("lw11",  1'b0, 2'b11, 1'b0, 32'h10,   '0, 1'b1, 4'b0000, '0, 32'h8081F2F3, 1'b0);
    d_op("lbwrap",1'b0, 2'b00, 1'b0, 32'h1013, '0, 1'b1, 4'b0000, '0, 32'hFFFFFF80, 1'b0);
    d_op("lbu3",  1'b0, 2'b00, 1'b1, 32'h13,   '0, 1'b1, 4'b0000, '0, 32'h00000080, 1'b0);
    d_op("lh0",   1'b0, 2'b01, 1'b0, 32'h14,   '0, 1'b1, 4'b0000, '0, 32'h00003344, 1'b0);

    // stores, then read back
    d_op("sb", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 1'b1, 4'b0010, 32'hABABABAB, 32'd0, 1'b0);
    d_op("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 32'd0, 1'b0);
    d_op("sw", 1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'd0, 1'b0);
    d_op("lw20", 1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b1, 4'b0000, '0, 32'h1234AB00, 1'b0);
    d_op("lw30", 1'b0, 2'b10, 1'b0, 32'h30, '0, 1'b1, 4'b0000, '0, 32'hDEADBEEF, 1'b0);

    // misaligned accesses never reach memory
    d_op("mlw", 1'b0, 2'b10, 1'b0, 32'h13, '0,           1'b0, 4'b0000, '0, 32'd0, 1'b1);
    d_op("mlh", 1'b0, 2'b01, 1'b0, 32'h15, '0,           1'b0, 4'b0000, '0, 32'd0, 1'b1);
    d_op("msw", 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, 1'b0, 4'b0000, '0, 32'd0, 1'b1);
    d_op("msh", 1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFFFFFF, 1'b0, 4'b0000, '0, 32'd0, 1'b1);
    d_op("keep20", 1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b1, 4'b0000, '0, 32'h1234AB00, 1'b0);
    d_op("keep14", 1'b0, 2'b10, 1'b0, 32'h14, '0, 1'b1, 4'b0000, '0, 32'h11223344, 1'b0);

    // contention: D wins four times, then IF, then D again
    bus.d_we    = 1'b0;
    bus.d_size  = 2'b10;
    bus.d_addr  = 32'h10;
    bus.if_addr = 32'h4;
    for (int j = 0; j < 8; j++) begin
      bus.if_req = (j < 6);
      bus.d_req  = (j < 6);
      #1;
      if (j < 6) begin
        chk($sformatf("cont%0d.if_stall", j), 32'(bus.if_stall), 32'(j != 4));
        chk($sformatf("cont%0d.d_stall", j), 32'(bus.d_stall), 32'(j == 4));
      end
      chk($sformatf("cont%0d.if_valid", j), 32'(bus.if_valid), 32'(j == 6));
      chk($sformatf("cont%0d.d_valid", j), 32'(bus.d_valid), 32'((j >= 2 && j <= 5) || j == 7));
      if (j == 6) chk("cont.if_rdata", bus.if_rdata, 32'h02534821);
      if (j == 7) chk("cont.d_rdata", bus.d_rdata, 32'h8081F2F3);
      cyc();
    end

    // reset with a load in flight and a partly starved fetch
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    bus.if_addr = 32'h0;
    #1;
    chk("r0.if_stall", 32'(bus.if_stall), 32'd1);
    chk("r0.d_stall", 32'(bus.d_stall), 32'd0);
    cyc();
    #1;
    chk("r1.d_stall", 32'(bus.d_stall), 32'd0);
    cyc();
    rst = 1'b1;
    #1;
    chk("r2.mem_en", 32'(bus.mem_en), 32'd0);
    chk("r2.if_stall", 32'(bus.if_stall), 32'd1);
    chk("r2.d_stall", 32'(bus.d_stall), 32'd1);
    chk("r2.d_valid", 32'(bus.d_valid), 32'd1);
    chk("r2.d_rdata", bus.d_rdata, 32'h8081F2F3);
    cyc();
    rst = 1'b0;
    #1;
    chk("r3.d_valid", 32'(bus.d_valid), 32'd0);
    chk("r3.if_valid", 32'(bus.if_valid), 32'd0);
    chk("r3.d_rdata", bus.d_rdata, 32'd0);
    chk("r3.if_rdata", bus.if_rdata, 32'd0);
    chk("r3.d_misalign", 32'(bus.d_misalign), 32'd0);
    chk("r3.if_stall", 32'(bus.if_stall), 32'd1);
    chk("r3.d_stall", 32'(bus.d_stall), 32'd0);
    cyc();
    for (int k = 4; k < 10; k++) begin
      bus.if_req = (k < 8);
      bus.d_req  = (k < 8);
      #1;
      if (k < 8) chk($sformatf("r%0d.if_stall", k), 32'(bus.if_stall), 32'(k != 7));
      chk($sformatf("r%0d.d_valid", k), 32'(bus.d_valid), 32'(k >= 5 && k <= 8));
      chk($sformatf("r%0d.if_valid", k), 32'(bus.if_valid), 32'(k == 9));
      if (k == 9) chk("r9.if_rdata", bus.if_rdata, 32'h02114020);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, synchronous-read, byte-writable memory between the instruction-fetch requester and the load/store requester. It arbitrates each cycle and drives the memory port with byte enables for stores. It realigns and sign- or zero-extends load data for LB/LH/LW/LBU/LHU, and stalls the requester that loses arbitration. It sits between the pipeline's IF/MEM stages and the unified memory array.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words)
STARVE_MAX, 4, consecutive lost cycles after which fetch wins over data (range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_stall=0
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_stall  out  1  combinational; 1 when if_req is present but not granted this cycle
if_valid  out  1  one-cycle pulse, fetch data valid
if_rdata  out  32  fetched instruction word
d_req  in  1  data request, held until d_stall=0
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
d_unsigned  in  1  1 = zero-extend load (LBU/LHU)
d_addr  in  32  data byte address
d_wdata  in  32  store data, right-justified
d_stall  out  1  combinational; 1 when d_req is present but not granted
d_valid  out  1  one-cycle pulse, data response (loads and stores)
d_rdata  out  32  extended load result; 0 for stores and errors
d_misalign  out  1  pulses with d_valid on a misaligned access
mem_en  out  1  memory access strobe
mem_we  out  4  byte write enables, bit i = byte lane i (little-endian lanes)
mem_addr  out  DEPTH_LOG2  word index
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data, valid the cycle after mem_en

Behaviour:
- Reset (rst=1 at a clock edge):
  - All registered outputs go to 0: if_valid, d_valid, d_misalign, if_rdata, d_rdata.
  - Starvation counter goes to 0.
  - In-flight responses are discarded and never produce a valid pulse.
  - While rst=1, mem_en=0, mem_we=0, and both stalls equal their req inputs.
- Arbitration (combinational, cycle N):
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both: grant D unless starve_cnt >= STARVE_MAX, then grant IF.
  - Loser's stall=1; winner's stall=0.
- Starvation counter:
  - Increments (saturating at 15) when if_req=1 and IF loses.
  - Clears when IF is granted, and when if_req=0.
- Memory port in grant cycle N:
  - mem_addr = granted addr[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses wrap modulo memory size.
  - IF grant: mem_en=1, mem_we=0.
  - D load (aligned): mem_en=1, mem_we=0.
  - D store (aligned): mem_en=1.
    - mem_we: byte = 1<<addr[1:0]; half = 0011 or 1100 selected by addr[1]; word = 1111.
    - mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Misaligned D request (half with addr[0]=1, or word with addr[1:0]!=0): counts as granted, but mem_en=0 and mem_we=0.
- Pipeline:
  - A 2-stage response tag is registered at cycle N: owner, load/store, size, unsigned, addr[1:0], misalign.
  - Response appears at N+2 as a one-cycle pulse: if_valid or d_valid.
  - Back-to-back grants are allowed every cycle (throughput 1/cycle).
  - Responses return in grant order, and at most one valid pulse occurs per cycle.
- Load extraction at N+2, from mem_rdata sampled at N+1:
  - Byte: lane addr[1:0], extended from bit 7 unless unsigned.
  - Half: lane addr[1], extended from bit 15 unless unsigned.
  - Word: passthrough; d_unsigned is ignored.
- Stores: d_valid at N+2 with d_rdata=0.
- Misaligned accesses: d_valid=1, d_misalign=1, d_rdata=0 at N+2; memory is untouched.
- Simultaneous request and reset: reset wins and nothing is granted.

Test Plan:
1. Fetch only: if_req=1 with addr 0x0, 0x4, 0x8 on consecutive cycles, memory words 0x02114020/0x02534821/0x02945022 → if_stall=0 throughout; if_valid pulses at cycles 2, 3, 4 with those words in order.
2. Loads with word at index 4 = 0x8081F2F3:
   - LB addr 0x10 → 0xFFFFFFF3
   - LBU addr 0x11 → 0x000000F2
   - LH addr 0x12 → 0xFFFF8081
   - LHU addr 0x12 → 0x00008081
   - LW addr 0x10 → 0x8081F2F3
3. Stores:
   - SB 0xAB to addr 0x21 → mem_we=0010, mem_wdata=0xABABABAB.
   - SH 0x1234 to addr 0x22 → mem_we=1100.
   - Each store gives d_valid at N+2 with d_rdata=0.
4. Contention with STARVE_MAX=4: if_req and d_req held high →
   - D is granted for 4 cycles with if_stall=1.
   - IF is granted on cycle 5 and the counter clears.
   - D is granted again on cycle 6.
5. Misaligned LW at 0x13 and LH at 0x15 → mem_en=0; d_valid=1, d_misalign=1, d_rdata=0 two cycles later; memory contents unchanged.
6. Assert rst one cycle after a load grant → no d_valid pulse; all outputs 0 the cycle after reset; starve_cnt=0; normal fetch resumes after rst deasserts.
